// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
// Game sequencer for the 5x7 LED snake datapath. Divides the clock into
// move ticks, commits the button direction (reversals rejected) and walks
// each step through MOVE -> CHECK -> EAT/OVER, keeping score and length.
// It only issues pulses; the coordinate/food datapath does the real work.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   l, r, u, d          direction buttons (level, synchronised), l > r > u > d
//   start               start/restart request (level)
//   hit_food, hit_body  datapath collision flags, sampled in CHECK
//   step                1-cycle pulse: shift snake one cell along dir
//   dir                 committed direction: 00 left, 01 right, 10 up, 11 down
//   grow                1-cycle pulse: keep tail this step
//   food_req            1-cycle pulse: load next food position
//   running             high in WAIT/MOVE/CHECK/EAT
//   game_over           high in OVER
//   score               foods eaten, saturating
//   length              current snake length
module snake_game_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int SCORE_W  = 8,
  parameter int MAX_LEN  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               l,
  input  logic               r,
  input  logic               u,
  input  logic               d,
  input  logic               start,
  input  logic               hit_food,
  input  logic               hit_body,
  output logic               step,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               food_req,
  output logic               running,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         length
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT, MOVE, CHECK, EAT, OVER
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic [1:0]         pending_dir, pending_next;
  logic [1:0]         req;
  logic               req_vld;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = INIT;
      INIT:  next_state = WAIT;
      WAIT:  if (tick) next_state = MOVE;
      MOVE:  next_state = CHECK;
      CHECK: begin
        if (hit_body)      next_state = OVER;
        else if (hit_food) next_state = EAT;
        else               next_state = WAIT;
      end
      EAT:   next_state = WAIT;
      OVER:  if (start) next_state = INIT;
      default: next_state = IDLE;
    endcase
  end

  // Direction request: highest-priority button, dropped if it reverses the
  // committed direction. Only listened to while the snake is moving.
  always_comb begin
    req          = 2'b00;
    req_vld      = 1'b0;
    pending_next = pending_dir;
    if (state == WAIT || state == MOVE || state == CHECK) begin
      req_vld = 1'b1;
      if (l)      req = 2'b00;
      else if (r) req = 2'b01;
      else if (u) req = 2'b10;
      else if (d) req = 2'b11;
      else        req_vld = 1'b0;
      if (req_vld && req != (dir ^ 2'b01)) pending_next = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= 1'b0;
      grow        <= 1'b0;
      food_req    <= 1'b0;
      running     <= 1'b0;
      game_over   <= 1'b0;
      dir         <= 2'b00;
      pending_dir <= 2'b00;
      score       <= '0;
      length      <= 4'd3;
      tick_cnt    <= '0;
      tick        <= 1'b0;
    end else begin
      state     <= next_state;
      // Pulses and status flags are registered from next_state so they line
      // up with the state they belong to.
      step      <= (next_state == MOVE);
      food_req  <= (next_state == INIT) || (next_state == EAT);
      grow      <= (next_state == EAT) && (length < 4'(MAX_LEN));
      running   <= (next_state == WAIT) || (next_state == MOVE) ||
                   (next_state == CHECK) || (next_state == EAT);
      game_over <= (next_state == OVER);

      if (next_state == INIT) begin
        score       <= '0;
        length      <= 4'd3;
        dir         <= 2'b00;
        pending_dir <= 2'b00;
        tick_cnt    <= '0;
        tick        <= 1'b0;
      end else begin
        pending_dir <= pending_next;
        // The wrap is registered as 'tick'; WAIT leaves on the cycle after,
        // so a WAIT stretch lasts TICK_DIV+1 cycles.
        if (state == WAIT) begin
          if (tick) begin
            tick <= 1'b0;
          end else if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        // Commit includes a request made in the last WAIT cycle.
        if (next_state == MOVE) dir <= pending_next;
        if (next_state == EAT) begin
          score <= sat_inc(score);
          if (length < 4'(MAX_LEN)) length <= length + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;
  localparam int TD = 4;
  localparam int ML = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       l = 0, r = 0, u = 0, d = 0, start = 0, hit_food = 0, hit_body = 0;
  logic       step, grow, food_req, running, game_over;
  logic [1:0] dir;
  logic [7:0] score;
  logic [3:0] length;
  logic       step_b, grow_b, food_req_b, running_b, game_over_b;
  logic [1:0] dir_b;
  logic [1:0] score_b;
  logic [3:0] length_b;

  snake_game_ctrl #(.TICK_DIV(TD), .SCORE_W(8), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .l(l), .r(r), .u(u), .d(d), .start(start),
    .hit_food(hit_food), .hit_body(hit_body), .step(step), .dir(dir),
    .grow(grow), .food_req(food_req), .running(running),
    .game_over(game_over), .score(score), .length(length));

  snake_game_ctrl #(.TICK_DIV(TD), .SCORE_W(2), .MAX_LEN(ML)) dut_b (
    .clk(clk), .rst_n(rst_n), .l(l), .r(r), .u(u), .d(d), .start(start),
    .hit_food(hit_food), .hit_body(hit_body), .step(step_b), .dir(dir_b),
    .grow(grow_b), .food_req(food_req_b), .running(running_b),
    .game_over(game_over_b), .score(score_b), .length(length_b));

  int n_cmp = 0;
  int n_err = 0;

  // Reference state, in game terms.
  logic [1:0] m_dir, m_pend;
  int         m_score, m_score_b, m_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_step, input bit e_grow,
                         input bit e_food, input bit e_run, input bit e_over);
    chk({tag, "/step"},      32'(step),      32'(e_step));
    chk({tag, "/grow"},      32'(grow),      32'(e_grow));
    chk({tag, "/food_req"},  32'(food_req),  32'(e_food));
    chk({tag, "/running"},   32'(running),   32'(e_run));
    chk({tag, "/game_over"}, 32'(game_over), 32'(e_over));
    chk({tag, "/dir"},       32'(dir),       32'(m_dir));
    chk({tag, "/score"},     32'(score),     32'(m_score));
    chk({tag, "/length"},    32'(length),    32'(m_len));
    chk({tag, "/b_step"},    32'(step_b),    32'(e_step));
    chk({tag, "/b_grow"},    32'(grow_b),    32'(e_grow));
    chk({tag, "/b_food"},    32'(food_req_b), 32'(e_food));
    chk({tag, "/b_run"},     32'(running_b), 32'(e_run));
    chk({tag, "/b_over"},    32'(game_over_b), 32'(e_over));
    chk({tag, "/b_dir"},     32'(dir_b),     32'(m_dir));
    chk({tag, "/b_score"},   32'(score_b),   32'(m_score_b));
    chk({tag, "/b_length"},  32'(length_b),  32'(m_len));
  endtask

  function automatic logic [1:0] opposite(input logic [1:0] x);
    case (x)
      2'b00:   return 2'b01;
      2'b01:   return 2'b00;
      2'b10:   return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Buttons packed {l,r,u,d}.
  function automatic logic [1:0] capture(input logic [1:0] pend, input logic [1:0] cur,
                                         input logic [3:0] b);
    logic [1:0] want;
    if (b[3])      want = 2'b00;
    else if (b[2]) want = 2'b01;
    else if (b[1]) want = 2'b10;
    else if (b[0]) want = 2'b11;
    else           return pend;
    if (want == opposite(cur)) return pend;
    return want;
  endfunction

  task automatic set_btn(input logic [3:0] b);
    {l, r, u, d} = b;
  endtask

  task automatic model_reset();
    m_dir = 2'b00; m_pend = 2'b00; m_score = 0; m_score_b = 0; m_len = 3;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Called at an observation point where the block is in IDLE or OVER.
  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    model_reset();
    chk_all("init", 0, 0, 1, 0, 0);
  endtask

  // One full move period starting with the first WAIT cycle.
  task automatic run_period(input bit food, input bit body, input bit rst_chk,
                            input bit rnd, input logic [3:0] btn, input bit hold_start);
    logic [3:0] b;
    bit g;
    start = hold_start;
    for (int i = 0; i < TD + 1; i++) begin
      cyc();
      hit_food = 1'b0; hit_body = 1'b0;
      chk_all("wait", 0, 0, 0, 1, 0);
      b = rnd ? 4'($urandom) : btn;
      set_btn(b);
      m_pend = capture(m_pend, m_dir, b);
    end
    cyc();
    m_dir = m_pend;
    chk_all("move", 1, 0, 0, 1, 0);
    b = rnd ? 4'($urandom) : btn;
    set_btn(b);
    m_pend = capture(m_pend, m_dir, b);
    cyc();
    chk_all("check", 0, 0, 0, 1, 0);
    b = rnd ? 4'($urandom) : btn;
    set_btn(b);
    m_pend = capture(m_pend, m_dir, b);
    start = 1'b0;
    hit_food = food; hit_body = body;
    if (rst_chk) begin
      #1 rst_n = 1'b0;
      #1 model_reset();
      chk_all("async_rst", 0, 0, 0, 0, 0);
      cyc();
      rst_n = 1'b1; hit_food = 1'b0; hit_body = 1'b0;
      chk_all("rst_held", 0, 0, 0, 0, 0);
    end else if (body) begin
      cyc();
      hit_food = 1'b0; hit_body = 1'b0;
      set_btn(4'($urandom));
      chk_all("over", 0, 0, 0, 0, 1);
    end else if (food) begin
      cyc();
      hit_food = 1'b0; hit_body = 1'b0;
      m_score   = (m_score == 255) ? 255 : m_score + 1;
      m_score_b = (m_score_b == 3) ? 3 : m_score_b + 1;
      g = (m_len < ML);
      if (g) m_len++;
      chk_all("eat", 0, g, 1, 1, 0);
      set_btn(4'($urandom)); // ignored while eating
    end
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    cyc();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // IDLE ignores buttons and collision flags.
    for (int i = 0; i < 3; i++) begin
      set_btn(4'($urandom)); hit_food = 1'b1;
      cyc();
      chk_all("idle", 0, 0, 0, 0, 0);
    end
    hit_food = 1'b0; set_btn(4'b0000);

    do_start();
    run_period(0, 0, 0, 0, 4'b0100, 0); // right is a reversal of left
    run_period(0, 0, 0, 0, 4'b0010, 0); // up
    run_period(0, 0, 0, 0, 4'b1001, 0); // left beats down
    for (int i = 0; i < 6; i++) run_period(1, 0, 0, 1, 4'b0000, 0);
    for (int i = 0; i < 6; i++) run_period(0, 0, 0, 1, 4'b0000, i == 2);
    run_period(1, 0, 0, 1, 4'b0000, 0);
    run_period(1, 1, 0, 1, 4'b0000, 0);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_btn(4'($urandom));
      cyc();
      chk_all("over_hold", 0, 0, 0, 0, 1);
    end

    do_start();
    run_period(0, 0, 0, 1, 4'b0000, 0);
    run_period(1, 0, 0, 1, 4'b0000, 0);
    run_period(0, 0, 1, 1, 4'b0000, 0);
    for (int i = 0; i < 4; i++) begin
      set_btn(4'($urandom));
      cyc();
      chk_all("post_rst_idle", 0, 0, 0, 0, 0);
    end
    do_start();
    for (int i = 0; i < 4; i++) run_period(i[0], 0, 0, 1, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
